// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one single-ported SRAM bank
// between NumReq requesters. It grants at most one access per cycle and drives the
// bank. It also tracks the owner of each in-flight access across the fixed
// MemLatency, so that each response goes back only to the requester that issued it.
//
// Optional feature (compile-time macro MEM_PORT_ARB_PRIO_EN):
//   When defined, requester 0 has strict priority. It is granted whenever it
//   requests, and those grants do not move the round-robin pointer. Round-robin
//   applies among requesters 1..NumReq-1 only while req_i[0] is low.
//   When undefined, the arbiter is pure round-robin over all requesters.

module mem_port_arbiter #(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned MemLatency = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_i,
    output logic [NumReq-1:0]               gnt_o,
    input  logic [NumReq*AddrWidth-1:0]     addr_i,
    input  logic [NumReq*DataWidth-1:0]     wdata_i,
    input  logic [NumReq*(DataWidth/8)-1:0] we_i,
    output logic [NumReq-1:0]               rvalid_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mem_en_o,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_we_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned BeW  = DataWidth / 8;
    localparam logic [IdxW:0] NumReqW = (IdxW + 1)'(NumReq);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    // ------------------------------------------------------------------
    // Round-robin state
    // ------------------------------------------------------------------
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    logic [IdxW-1:0] winner;
    logic            found;
    logic            ptr_adv;
    logic [IdxW:0]   cand_sum;
    logic [IdxW-1:0] cand;

    // Winner search: first set request at or after rr_ptr, wrapping modulo NumReq.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
            if (cand_sum >= NumReqW) begin
                cand_sum = cand_sum - NumReqW;
            end
            cand = cand_sum[IdxW-1:0];
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef MEM_PORT_ARB_PRIO_EN
        // Requester 0 overrides the rotating search entirely.
        if (req_i[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

    // Decide whether this cycle's grant moves the pointer.
    always_comb begin
        ptr_adv = found;
`ifdef MEM_PORT_ARB_PRIO_EN
        // Priority grants to requester 0 leave the rotation untouched.
        if (req_i[0]) begin
            ptr_adv = 1'b0;
        end
`endif
    end

    // Next pointer: one past the winner, wrapping to 0 after the last requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (ptr_adv) begin
            rr_ptr_d = (winner == LastIdx) ? '0 : winner + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Grant decode and bank drive
    // ------------------------------------------------------------------

    // One-hot grant from the winner index.
    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            gnt_o[k] = found && (winner == IdxW'(k));
        end
    end

    // AND-OR mux of the winner's payload; all-zero when nothing is granted.
    always_comb begin
        mem_en_o    = found;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_o[k]) begin
                mem_addr_o  = mem_addr_o  | addr_i[k*AddrWidth +: AddrWidth];
                mem_wdata_o = mem_wdata_o | wdata_i[k*DataWidth +: DataWidth];
                mem_we_o    = mem_we_o    | we_i[k*BeW +: BeW];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response tracking: {valid, owner} shifted alongside the bank latency
    // ------------------------------------------------------------------
    logic [MemLatency-1:0]           pipe_vld_q, pipe_vld_d;
    logic [MemLatency-1:0][IdxW-1:0] pipe_own_q, pipe_own_d;

    // Stage 0 captures this cycle's access; later stages shift forward.
    always_comb begin
        pipe_vld_d    = pipe_vld_q;
        pipe_own_d    = pipe_own_q;
        pipe_vld_d[0] = mem_en_o;
        pipe_own_d[0] = winner;
        for (int j = 1; j < MemLatency; j++) begin
            pipe_vld_d[j] = pipe_vld_q[j-1];
            pipe_own_d[j] = pipe_own_q[j-1];
        end
    end

    // Pipeline registers; reset drops every in-flight access silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld_q <= '0;
            pipe_own_q <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_own_q <= pipe_own_d;
        end
    end

    // Route the returning response to its owner; data is gated to zero when idle.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        for (int k = 0; k < NumReq; k++) begin
            rvalid_o[k] = pipe_vld_q[MemLatency-1] && (pipe_own_q[MemLatency-1] == IdxW'(k));
        end
        if (pipe_vld_q[MemLatency-1]) begin
            rdata_o = mem_rdata_i;
        end
    end

endmodule
